debounce: RTL and testbench
===========================

Name: debounce

Overview:
Debounces one asynchronous input, such as a push-button or switch, into a clean, single-clock-domain level.
- Synchronizes the raw input into the `clk` domain.
- Output changes only after the synchronized input has held the opposite value for DEBOUNCE_CLKS consecutive cycles.
- Sits between board I/O pins and user logic in the top-level designs.

Parameters:
DEBOUNCE_CLKS, 10000, consecutive stable clocks required before the output changes (10000 = 100 us at 100 MHz); legal range >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
async_in  input  1  raw asynchronous input (bouncy).
debounce_out  output  1  debounced, registered level.

Behaviour:
- Clock and reset: one clock (`clk`). Reset `rst` is asynchronous and active-high. All flops (sync stages, counter, output) clear to 0 while `rst` = 1; debounce_out = 0 during and after reset.
- Synchronizer: 2-flop chain, async_in -> s1 -> s2. The chain's output is `sync_in`. No logic between the stages.
- Counter:
  - Width CNT_W = $clog2(DEBOUNCE_CLKS+1).
  - Each rising edge: if sync_in == debounce_out, counter <= 0.
  - Else if counter == DEBOUNCE_CLKS-1, then debounce_out <= sync_in and counter <= 0.
  - Else counter <= counter + 1.
- Result: the output toggles on the DEBOUNCE_CLKS-th consecutive cycle on which sync_in differs from debounce_out.
- Latency: a clean step on async_in reaches debounce_out in DEBOUNCE_CLKS+2 cycles (+1 cycle of async sampling uncertainty). The output must NOT change earlier than DEBOUNCE_CLKS-2 cycles after the step, and MUST change within DEBOUNCE_CLKS+10.
- Runt or bounce: any single cycle where sync_in equals debounce_out clears the counter. Glitches therefore never accumulate; the count restarts from 0.
- Symmetric: identical rules for 0->1 and 1->0.
- Reset mid-count: counter and output return to 0 immediately. A pending transition is discarded.
- Counter never exceeds DEBOUNCE_CLKS-1; no wrap-around.
- debounce_out is a direct flop output (glitch-free, no combinational path from async_in).

Optional Feature:
Macro DEBOUNCE_SYNC3_EN.
- Defined: the synchronizer uses 3 flops (for MTBF on fast clocks); latency becomes DEBOUNCE_CLKS+3.
- Undefined: 2-flop synchronizer as above.
- Counter and output behaviour are identical either way.

Decomposition:
- Package debounce_pkg:
  - DEFAULT_DEBOUNCE_CLKS = 10000.
  - Constant function debounce_clks(delay_us, clk_hz) = delay_us*clk_hz/1_000_000.
  - Counter-width helper based on $clog2.
- One natural sub-module: debounce_sync.
  - Parameterized N-stage synchronizer, N = 2 or 3.
  - Async active-high reset to 0.
  - Instantiated once inside debounce.

Test Plan (DEBOUNCE_CLKS=10000, 100 MHz clk):
- Reset: rst=1 for 80 ns, then release; async_in=0 -> debounce_out=0 throughout and for 1000 cycles after.
- Clean rise: async_in 0->1 and hold -> debounce_out stays 0 for >= 9998 cycles, then reads 1 within the next 10 cycles (nominally cycle 10002).
- Clean fall: async_in 1->0 and hold -> same timing window with debounce_out 1->0.
- Single runt: async_in toggled for 2 cycles, then restored -> debounce_out unchanged for 10010 cycles.
- Accumulating runts: async_in alternates each cycle (differs, equals) for 20010 iterations -> debounce_out never changes.
- Reset mid-count: step async_in, assert rst at count ~5000 -> debounce_out=0 immediately. After release with async_in still 1, the output rises only after a full DEBOUNCE_CLKS+2 cycles.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - debounce defaults and compile-time sizing helpers
package debounce_pkg;

  localparam int DEFAULT_DEBOUNCE_CLKS = 10000;

  // Converts a debounce time in microseconds to a clock count at clk_hz.
  function automatic int debounce_clks(input longint delay_us, input longint clk_hz);
    return int'((delay_us * clk_hz) / 64'd1_000_000);
  endfunction

  function automatic int cnt_width(input int clks);
    return $clog2(clks + 1);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - N-stage flop synchronizer, async active-high reset to 0
module debounce_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/debounce.sv
// rtl/debounce.sv - input debouncer; DEBOUNCE_SYNC3_EN selects a 3-flop synchronizer
module debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CLKS = DEFAULT_DEBOUNCE_CLKS
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic debounce_out
);

`ifdef DEBOUNCE_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CLKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync_in;
  logic [CNT_W-1:0] cnt;

  debounce_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(async_in),
    .sync_out(sync_in)
  );

  // Any cycle agreeing with the output restarts the count, so bounces never accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      debounce_out <= 1'b0;
    end else if (sync_in == debounce_out) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      debounce_out <= sync_in;
      cnt          <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_debounce.sv
// tb/tb_debounce.sv - scoreboard bench for debounce
module tb_debounce;

  localparam int D = 10000;
`ifdef DEBOUNCE_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif
  localparam int LAT = D + SYNC_N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic async_in = 1'b0;
  logic debounce_out;

  debounce #(
    .DEBOUNCE_CLKS(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .async_in    (async_in),
    .debounce_out(debounce_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    start;
    int    lo;
    int    hi;
    logic  val;
    string name;
  } chg_t;

  typedef struct {
    int    at;
    logic  val;
    string name;
  } lvl_t;

  chg_t chg_q[$];
  lvl_t lvl_q[$];

  int passed = 0;
  int total  = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d cycles, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Monitor: every output edge must match the next expected transition.
  logic prev = 1'b0;
  chg_t e_chg;
  lvl_t e_lvl;
  always @(negedge clk) begin
    if (debounce_out !== prev) begin
      if (chg_q.size() == 0) begin
        check_bit("unexpected_change", debounce_out, prev);
      end else begin
        e_chg = chg_q.pop_front();
        check_bit({e_chg.name, "_value"}, debounce_out, e_chg.val);
        check_range({e_chg.name, "_latency"}, cyc - e_chg.start, e_chg.lo, e_chg.hi);
      end
      prev = debounce_out;
    end
    while (lvl_q.size() != 0 && lvl_q[0].at <= cyc) begin
      e_lvl = lvl_q.pop_front();
      check_bit(e_lvl.name, debounce_out, e_lvl.val);
    end
  end

  task automatic do_step(input logic v, input string name);
    int c;
    @(negedge clk);
    async_in = v;
    c = cyc;
    lvl_q.push_back('{at: c + D - 2, val: ~v, name: {name, "_hold"}});
    chg_q.push_back('{start: c, lo: LAT, hi: LAT + 1, val: v, name: name});
    lvl_q.push_back('{at: c + LAT + 5, val: v, name: {name, "_settled"}});
    repeat (LAT + 10) @(negedge clk);
  endtask

  initial begin
    int r;
    lvl_q.push_back('{at: 2, val: 1'b0, name: "in_reset"});
    lvl_q.push_back('{at: 500, val: 1'b0, name: "post_reset_500"});
    lvl_q.push_back('{at: 1000, val: 1'b0, name: "post_reset_1000"});
    #80 rst = 1'b0;
    repeat (1000) @(negedge clk);

    do_step(1'b1, "rise");
    do_step(1'b0, "fall");

    // Two-cycle runt while the output is low.
    @(negedge clk);
    async_in = 1'b1;
    repeat (2) @(negedge clk);
    async_in = 1'b0;
    lvl_q.push_back('{at: cyc + D + 10, val: 1'b0, name: "runt"});
    repeat (D + 12) @(negedge clk);

    // Alternating input: the counter must clear every other cycle.
    for (int i = 0; i < 20010; i++) begin
      @(negedge clk);
      async_in = (i % 2 == 0);
      if (i == 12000) lvl_q.push_back('{at: cyc + 1, val: 1'b0, name: "alternating_mid"});
    end
    lvl_q.push_back('{at: cyc + 5, val: 1'b0, name: "alternating_end"});
    repeat (10) @(negedge clk);

    // Reset roughly halfway through a pending rise.
    @(negedge clk);
    async_in = 1'b1;
    repeat (5000) @(negedge clk);
    rst = 1'b1;
    lvl_q.push_back('{at: cyc + 1, val: 1'b0, name: "reset_mid_count"});
    repeat (5) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    lvl_q.push_back('{at: r + D - 2, val: 1'b0, name: "after_reset_hold"});
    chg_q.push_back('{start: r, lo: LAT, hi: LAT + 1, val: 1'b1, name: "after_reset"});
    lvl_q.push_back('{at: r + LAT + 5, val: 1'b1, name: "after_reset_settled"});
    repeat (LAT + 10) @(negedge clk);

    // Reset while the output is high must drop it at once.
    async_in = 1'b0;
    rst = 1'b1;
    chg_q.push_back('{start: cyc, lo: 0, hi: 1, val: 1'b0, name: "reset_high"});
    lvl_q.push_back('{at: cyc + 2, val: 1'b0, name: "reset_high_level"});
    repeat (4) @(negedge clk);
    rst = 1'b0;
    lvl_q.push_back('{at: cyc + 20, val: 1'b0, name: "final_level"});
    repeat (30) @(negedge clk);

    while (chg_q.size() != 0) begin
      e_chg = chg_q.pop_front();
      check_range({e_chg.name, "_missing"}, cyc - e_chg.start, e_chg.lo, e_chg.hi);
    end
    while (lvl_q.size() != 0) begin
      e_lvl = lvl_q.pop_front();
      check_bit({e_lvl.name, "_late"}, debounce_out, e_lvl.val);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
